// File: rtl/seg7_pkg.sv
// Shared glyph encodings, ASCII codes and the banner for the 7-segment letter reader.
// Segment order is bit6=a .. bit0=g, 1 = segment lit.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_S     = 7'b1011011;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_N     = 7'b0010101;
   localparam logic [6:0] SEG_O     = 7'b1111110;
   localparam logic [6:0] SEG_L     = 7'b0001110;
   localparam logic [6:0] SEG_G     = 7'b1011111;
   localparam logic [6:0] SEG_U     = 7'b0111110;

   localparam logic [7:0] ASCII_S       = 8'h53;
   localparam logic [7:0] ASCII_E       = 8'h45;
   localparam logic [7:0] ASCII_N       = 8'h6E;
   localparam logic [7:0] ASCII_O       = 8'h4F;
   localparam logic [7:0] ASCII_L       = 8'h4C;
   localparam logic [7:0] ASCII_G       = 8'h47;
   localparam logic [7:0] ASCII_U       = 8'h55;
   localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

   localparam int SEQ_LEN = 13;

   // The only n-shaped glyph a 7-segment digit can show is lowercase, so both
   // n positions of the banner expect the code that glyph decodes to.
   localparam logic [7:0] EXPECTED [0:SEQ_LEN-1] = '{
      ASCII_S, ASCII_E, ASCII_N, ASCII_O, ASCII_L, ASCII_G, ASCII_U,
      ASCII_L, ASCII_G, ASCII_O, ASCII_N, ASCII_U, ASCII_L
   };

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational segment pattern to ASCII decoder; unrecognised patterns map to '?'.
module seg7_char_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern,
   output logic       known,
   output logic [7:0] ascii
);

   always_comb begin
      known = 1'b1;
      ascii = ASCII_UNKNOWN;
      case (pattern)
         SEG_S:   ascii = ASCII_S;
         SEG_E:   ascii = ASCII_E;
         SEG_N:   ascii = ASCII_N;
         SEG_O:   ascii = ASCII_O;
         SEG_L:   ascii = ASCII_L;
         SEG_G:   ascii = ASCII_G;
         SEG_U:   ascii = ASCII_U;
         default: known = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_letter_reader.sv
// Loopback reader: synchronises and debounces the segment bus, decodes accepted
// glyphs and tracks them against the expected banner.
module seg7_letter_reader
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       seg_in,
   output logic             char_valid,
   output logic [7:0]       char_code,
   output logic             char_known,
   output logic [3:0]       seq_pos,
   output logic             seq_match,
   output logic             seq_error,
   output logic [CNT_W-1:0] match_count
);

   localparam int             STB_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYCLES);
   localparam logic [3:0]     LAST_POS = 4'(SEQ_LEN - 1);

   logic [6:0]       s1_q, s1_d, s2_q, s2_d, last_q, last_d;
   logic [STB_W-1:0] stb_q, stb_d;
   logic             char_valid_q, char_valid_d;
   logic [7:0]       char_code_q, char_code_d;
   logic             char_known_q, char_known_d;
   logic [3:0]       seq_pos_q, seq_pos_d;
   logic             seq_match_q, seq_match_d;
   logic             seq_error_q, seq_error_d;
   logic [CNT_W-1:0] match_count_q, match_count_d;

   logic             reach;
   logic             accept;
   logic             dec_known;
   logic [7:0]       dec_ascii;

   seg7_char_decode u_decode (
      .pattern (s2_q),
      .known   (dec_known),
      .ascii   (dec_ascii)
   );

   always_comb begin
      s1_d          = seg_in;
      s2_d          = s1_q;
      stb_d         = stb_q;
      last_d        = last_q;
      char_valid_d  = 1'b0;
      char_code_d   = char_code_q;
      char_known_d  = char_known_q;
      seq_pos_d     = seq_pos_q;
      seq_match_d   = 1'b0;
      seq_error_d   = 1'b0;
      match_count_d = match_count_q;

      // The counter looks at the value s2 is about to take, so the accept
      // pulse appears on the edge where s2 has been stable STABLE_CYCLES times.
      if (s1_q != s2_q) begin
         stb_d = '0;
      end else if (stb_q != STB_MAX) begin
         stb_d = stb_q + 1'b1;
      end

      reach  = (s1_q == s2_q) && (stb_q != STB_MAX) && (stb_d == STB_MAX);
      accept = reach && (s2_q != last_q) && (s2_q != SEG_BLANK);

      // A stable blank also lands here, clearing last so a repeat is re-accepted.
      if (reach) begin
         last_d = s2_q;
      end

      if (accept) begin
         char_valid_d = 1'b1;
         char_code_d  = dec_ascii;
         char_known_d = dec_known;
         if (dec_known && (dec_ascii == EXPECTED[seq_pos_q])) begin
            if (seq_pos_q == LAST_POS) begin
               seq_match_d = 1'b1;
               seq_pos_d   = 4'd0;
               if (match_count_q != '1) begin
                  match_count_d = match_count_q + 1'b1;
               end
            end else begin
               seq_pos_d = seq_pos_q + 4'd1;
            end
         end else begin
            seq_error_d = (seq_pos_q != 4'd0);
            seq_pos_d   = (dec_known && (dec_ascii == ASCII_S)) ? 4'd1 : 4'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q          <= '0;
         s2_q          <= '0;
         stb_q         <= '0;
         last_q        <= SEG_BLANK;
         char_valid_q  <= 1'b0;
         char_code_q   <= '0;
         char_known_q  <= 1'b0;
         seq_pos_q     <= '0;
         seq_match_q   <= 1'b0;
         seq_error_q   <= 1'b0;
         match_count_q <= '0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         stb_q         <= stb_d;
         last_q        <= last_d;
         char_valid_q  <= char_valid_d;
         char_code_q   <= char_code_d;
         char_known_q  <= char_known_d;
         seq_pos_q     <= seq_pos_d;
         seq_match_q   <= seq_match_d;
         seq_error_q   <= seq_error_d;
         match_count_q <= match_count_d;
      end
   end

   assign char_valid  = char_valid_q;
   assign char_code   = char_code_q;
   assign char_known  = char_known_q;
   assign seq_pos     = seq_pos_q;
   assign seq_match   = seq_match_q;
   assign seq_error   = seq_error_q;
   assign match_count = match_count_q;

endmodule

// File: tb/tb_seg7_letter_reader.sv
// Scoreboard bench for seg7_letter_reader: a default instance plus a CNT_W=2
// instance share the segment bus; expected glyph events are queued when driven.
module tb_seg7_letter_reader;

   localparam int STB = 4;

   localparam logic [6:0] G_S = 7'b1011011;
   localparam logic [6:0] G_E = 7'b1001111;
   localparam logic [6:0] G_N = 7'b0010101;
   localparam logic [6:0] G_O = 7'b1111110;
   localparam logic [6:0] G_L = 7'b0001110;
   localparam logic [6:0] G_G = 7'b1011111;
   localparam logic [6:0] G_U = 7'b0111110;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg_in = G_S;

   logic       char_valid, char_known, seq_match, seq_error;
   logic [7:0] char_code, match_count;
   logic [3:0] seq_pos;
   logic       s_char_valid, s_char_known, s_seq_match, s_seq_error;
   logic [7:0] s_char_code;
   logic [3:0] s_seq_pos;
   logic [1:0] s_match_count;

   seg7_letter_reader #(.STABLE_CYCLES(STB), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in),
      .char_valid(char_valid), .char_code(char_code), .char_known(char_known),
      .seq_pos(seq_pos), .seq_match(seq_match), .seq_error(seq_error),
      .match_count(match_count)
   );

   seg7_letter_reader #(.STABLE_CYCLES(STB), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .seg_in(seg_in),
      .char_valid(s_char_valid), .char_code(s_char_code), .char_known(s_char_known),
      .seq_pos(s_seq_pos), .seq_match(s_seq_match), .seq_error(s_seq_error),
      .match_count(s_match_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [7:0] code;
      logic       known;
      int         pos;
      logic       m;
      logic       e;
      int         cnt;
      int         cnt_sat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int n_pass = 0;
   int n_checks = 0;
   int pulses = 0;
   int p0;

   logic [6:0] banner_seg [13] = '{G_S, G_E, G_N, G_O, G_L, G_G, G_U, G_L, G_G, G_O, G_N, G_U, G_L};
   byte unsigned banner_a [13] = '{"S", "E", "n", "O", "L", "G", "U", "L", "G", "O", "n", "U", "L"};

   logic [6:0] m_last;
   int         m_pos, m_cnt, m_cnts;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [8:0] tb_decode(input logic [6:0] p);
      case (p)
         7'b1011011: return {1'b1, 8'h53};
         7'b1001111: return {1'b1, 8'h45};
         7'b0010101: return {1'b1, 8'h6E};
         7'b1111110: return {1'b1, 8'h4F};
         7'b0001110: return {1'b1, 8'h4C};
         7'b1011111: return {1'b1, 8'h47};
         7'b0111110: return {1'b1, 8'h55};
         default:    return {1'b0, 8'h3F};
      endcase
   endfunction

   task automatic model_reset();
      m_last = 7'd0;
      m_pos  = 0;
      m_cnt  = 0;
      m_cnts = 0;
   endtask

   // Called at a falling edge as g appears on seg_in; g must then be held > STB cycles.
   task automatic push_glyph(input logic [6:0] g);
      exp_t       e;
      logic [8:0] d;
      if (g != 7'd0 && g != m_last) begin
         d       = tb_decode(g);
         e.cyc   = cyc + 2 + STB;
         e.code  = d[7:0];
         e.known = d[8];
         e.m     = 1'b0;
         e.e     = 1'b0;
         if (e.known && e.code == banner_a[m_pos]) begin
            if (m_pos == 12) begin
               e.m   = 1'b1;
               m_pos = 0;
               if (m_cnt < 255) m_cnt++;
               if (m_cnts < 3) m_cnts++;
            end else begin
               m_pos++;
            end
         end else begin
            e.e   = (m_pos != 0);
            m_pos = (e.known && e.code == 8'h53) ? 1 : 0;
         end
         e.pos     = m_pos;
         e.cnt     = m_cnt;
         e.cnt_sat = m_cnts;
         sb.push_back(e);
      end
      m_last = g;
   endtask

   task automatic show(input logic [6:0] g, input int n);
      seg_in = g;
      push_glyph(g);
      repeat (n) @(negedge clk);
   endtask

   task automatic show_banner();
      for (int i = 0; i < 13; i++) begin
         show(banner_seg[i], 10);
         show(7'd0, 10);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_valid"}, char_valid, 0);
      check_val({tag, "_code"}, char_code, 0);
      check_val({tag, "_known"}, char_known, 0);
      check_val({tag, "_pos"}, seq_pos, 0);
      check_val({tag, "_flags"}, {seq_match, seq_error}, 0);
      check_val({tag, "_count"}, match_count, 0);
      check_val({tag, "_sat_count"}, s_match_count, 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (char_valid) begin
            pulses++;
            if (sb.size() == 0) begin
               check_val("unexpected_pulse", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check_val("latency_cycle", cyc, mon_e.cyc);
               check_val("code", char_code, mon_e.code);
               check_val("known", char_known, mon_e.known);
               check_val("seq_pos", seq_pos, mon_e.pos);
               check_val("seq_match", seq_match, mon_e.m);
               check_val("seq_error", seq_error, mon_e.e);
               check_val("match_count", match_count, mon_e.cnt);
               check_val("sat_valid", s_char_valid, 1);
               check_val("sat_count", s_match_count, mon_e.cnt_sat);
            end
         end else if (seq_match || seq_error || s_char_valid) begin
            check_val("pulse_without_valid", {seq_match, seq_error, s_char_valid}, 0);
         end
      end
   end

   initial begin
      model_reset();
      // Reset with S already on the bus, then S is accepted after release.
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      push_glyph(G_S);
      repeat (10) @(negedge clk);
      show(7'd0, 10);

      // Two-cycle glitch must be filtered out.
      p0 = pulses;
      seg_in = G_E;
      repeat (2) @(negedge clk);
      seg_in = 7'd0;
      repeat (12) @(negedge clk);
      check_val("glitch_pulses", pulses - p0, 0);

      // Banner (S from the reset test already counts as position 1).
      p0 = pulses;
      for (int i = 1; i < 13; i++) begin
         show(banner_seg[i], 10);
         show(7'd0, 10);
      end
      check_val("banner_pulses", pulses - p0, 12);
      check_val("banner_count", match_count, 1);
      check_val("banner_pos", seq_pos, 0);

      // Broken match then restart on S.
      show(G_S, 10); show(7'd0, 10);
      show(G_E, 10); show(7'd0, 10);
      show(G_N, 10); show(7'd0, 10);
      show(G_G, 10); show(7'd0, 10);
      show(G_S, 10); show(7'd0, 10);
      check_val("break_pos", seq_pos, 1);

      // Unknown glyph, long hold, and repeat after blank.
      show(7'b1110000, 10); show(7'd0, 10);
      check_val("unknown_code_held", char_code, 8'h3F);
      p0 = pulses;
      show(G_L, 50);
      check_val("hold_pulses", pulses - p0, 1);
      show(7'd0, 10);
      show(G_L, 10);
      show(7'd0, 10);
      check_val("repeat_pulses", pulses - p0, 2);

      // Three more banners: four in total, so the 2-bit counter saturates.
      for (int b = 0; b < 3; b++) show_banner();
      check_val("count_after_4", match_count, 4);
      check_val("sat_count_after_4", s_match_count, 3);

      // Reset in the middle of a banner.
      for (int i = 0; i < 7; i++) begin
         show(banner_seg[i], 10);
         show(7'd0, 10);
      end
      check_val("mid_pos", seq_pos, m_pos);
      rst = 1'b1;
      seg_in = G_S;
      model_reset();
      @(negedge clk);
      check_reset_state("mid_reset");
      rst = 1'b0;
      push_glyph(G_S);
      repeat (12) @(negedge clk);

      check_val("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
